wb_port_arbiter: RTL

//  Shares the register file's single write port between NREQ write-back sources
//  (e.g. 0=ALU, 1=load unit, 2=mul/div unit) with round-robin arbitration.

---
 rtl/wb_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ write-back sources.
// Also keeps the busy scoreboard that decode uses for RAW hazard stalls.
module wb_port_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 claim_valid,
  input  logic [AW-1:0]        claim_addr,
  output logic [31:0]          busy,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_addr,
  output logic [XLEN-1:0]      rf_data,
  output logic [2:0]           grant_id
);

  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_addr_q, rf_addr_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic [31:0]     busy_q, busy_d;

  logic            grant_found_s;
  logic [2:0]      grant_idx_s;
  logic [3:0]      cand_s;
  logic            xfer_s;
  logic [AW-1:0]   win_addr_s;
  logic [XLEN-1:0] win_data_s;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = 3'd0;
    cand_s        = 4'd0;
    for (int off = 0; off < NREQ; off++) begin
      cand_s = {1'b0, rr_ptr_q} + 4'(off);
      if (cand_s >= 4'(NREQ)) begin
        cand_s = cand_s - 4'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s[2:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[2:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot ready, forced low while reset is asserted so nothing transfers during reset.
  always_comb begin
    req_ready = '0;
    if (grant_found_s && rst) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign xfer_s     = grant_found_s & rst;
  assign win_addr_s = req_addr[grant_idx_s*AW +: AW];
  assign win_data_s = req_data[grant_idx_s*XLEN +: XLEN];

  // Next-state for pointer and write stage; x0 writes are accepted but never reach the port.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    grant_id_d = grant_id_q;
    if (xfer_s) begin
      if (grant_idx_s == 3'(NREQ - 1)) begin
        rr_ptr_d = 3'd0;
      end else begin
        rr_ptr_d = grant_idx_s + 3'd1;
      end
      if (win_addr_s != '0) begin
        rf_we_d    = 1'b1;
        rf_addr_d  = win_addr_s;
        rf_data_d  = win_data_s;
        grant_id_d = grant_idx_s;
      end else begin
        rf_we_d = 1'b0;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Scoreboard: commit clears first so a same-edge claim of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_addr_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (claim_valid && (claim_addr != '0)) begin
      busy_d[claim_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; async reset discards any in-flight write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= 3'd0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      grant_id_q <= 3'd0;
      busy_q     <= 32'd0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_data  = rf_data_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule
